// File: rtl/sd_host_regfile.sv
// sd_host_regfile: SD host controller register file with command launch, W1C interrupt status and ADMA address.
// Word-access host port with byte lanes, registered read data, and a registered interrupt output.
module sd_host_regfile #(
    parameter int ADDR_W = 13,
    parameter int DMA_AW = 64,
    parameter int NIRQ   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addrs_i,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_data_i,
    input  logic [3:0]        be_i,
    input  logic              rd_en_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    input  logic [NIRQ-1:0]   hw_int_set_i,
    input  logic [15:0]       hw_err_set_i,
    input  logic              hw_resp_we_i,
    input  logic [31:0]       hw_resp_i,
    input  logic              cmd_busy_i,
    input  logic              dat_busy_i,
    output logic [11:0]       blk_size_o,
    output logic [15:0]       blk_cnt_o,
    output logic [31:0]       cmd_arg_o,
    output logic [15:0]       xfer_mode_o,
    output logic [15:0]       cmd_reg_o,
    output logic [DMA_AW-1:0] adma_addr_o,
    output logic              cmd_start_o,
    output logic              cmd_drop_o,
    output logic              irq_o
);
    localparam logic [15:0] NMASK  = 16'((32'd1 << NIRQ) - 32'd1);
    localparam logic        HAS_HI = (DMA_AW == 64);

    logic [ADDR_W-1:0] a;
    logic [31:0] blk_q, blk_d, arg_q, arg_d, cmdx_q, cmdx_d, resp_q, resp_d;
    logic [31:0] sts_q, sts_d, en_q, en_d, sig_q, sig_d;
    logic [63:0] adma_q, adma_d;
    logic [31:0] rd_data_q, rd_data_d, rd_mux, bm, cmdx_m, set, clr;
    logic        rd_valid_q, cmd_start_q, cmd_start_d, cmd_drop_q, cmd_drop_d, irq_q, irq_d;
    logic        w04, w08, w0c, w30, w34, w38, w58, w5c;

    assign a  = {addrs_i[ADDR_W-1:2], 2'b00};
    assign bm = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

    assign w04 = wr_en_i && a == ADDR_W'(32'h04);
    assign w08 = wr_en_i && a == ADDR_W'(32'h08);
    assign w0c = wr_en_i && a == ADDR_W'(32'h0C);
    assign w30 = wr_en_i && a == ADDR_W'(32'h30);
    assign w34 = wr_en_i && a == ADDR_W'(32'h34);
    assign w38 = wr_en_i && a == ADDR_W'(32'h38);
    assign w58 = wr_en_i && a == ADDR_W'(32'h58);
    assign w5c = wr_en_i && a == ADDR_W'(32'h5C) && HAS_HI;

    always_comb begin
        // dat_busy freezes the transfer setup; cmd_busy freezes the whole command word
        blk_d  = (w04 && !dat_busy_i) ? ((blk_q & ~bm) | (wr_data_i & bm)) & 32'hFFFF_0FFF : blk_q;
        arg_d  = w08 ? (arg_q & ~bm) | (wr_data_i & bm) : arg_q;
        cmdx_m = (cmdx_q & ~bm) | (wr_data_i & bm);
        cmdx_d = (w0c && !cmd_busy_i) ? {cmdx_m[31:16], dat_busy_i ? cmdx_q[15:0] : cmdx_m[15:0]} : cmdx_q;
        resp_d = hw_resp_we_i ? hw_resp_i : resp_q;
        en_d   = w34 ? (en_q & ~bm) | (wr_data_i & bm) : en_q;
        sig_d  = w38 ? (sig_q & ~bm) | (wr_data_i & bm) : sig_q;
        // a hardware set wins over a same-cycle write-1-to-clear
        set    = {hw_err_set_i, 16'(hw_int_set_i)} & en_q;
        clr    = w30 ? wr_data_i & bm : 32'h0;
        sts_d  = ((sts_q & ~clr) | set) & {16'hFFFF, NMASK};
        adma_d = {w5c ? (adma_q[63:32] & ~bm) | (wr_data_i & bm) : adma_q[63:32],
                  w58 ? (adma_q[31:0] & ~bm) | (wr_data_i & bm) : adma_q[31:0]};
        rd_mux = a == ADDR_W'(32'h04) ? blk_q :
                 a == ADDR_W'(32'h08) ? arg_q :
                 a == ADDR_W'(32'h0C) ? cmdx_q :
                 a == ADDR_W'(32'h10) ? resp_q :
                 a == ADDR_W'(32'h24) ? {30'b0, dat_busy_i, cmd_busy_i} :
                 a == ADDR_W'(32'h30) ? sts_q :
                 a == ADDR_W'(32'h34) ? en_q :
                 a == ADDR_W'(32'h38) ? sig_q :
                 a == ADDR_W'(32'h58) ? adma_q[31:0] :
                 (a == ADDR_W'(32'h5C) && HAS_HI) ? adma_q[63:32] : 32'h0;
        rd_data_d   = rd_en_i ? rd_mux : rd_data_q;
        cmd_start_d = w0c && be_i[3] && !cmd_busy_i;
        cmd_drop_d  = w0c && be_i[3] && cmd_busy_i;
        irq_d       = |(sts_q & sig_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blk_q       <= '0;
            arg_q       <= '0;
            cmdx_q      <= '0;
            resp_q      <= '0;
            sts_q       <= '0;
            en_q        <= '0;
            sig_q       <= '0;
            adma_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_start_q <= 1'b0;
            cmd_drop_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            blk_q       <= blk_d;
            arg_q       <= arg_d;
            cmdx_q      <= cmdx_d;
            resp_q      <= resp_d;
            sts_q       <= sts_d;
            en_q        <= en_d;
            sig_q       <= sig_d;
            adma_q      <= adma_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_en_i;
            cmd_start_q <= cmd_start_d;
            cmd_drop_q  <= cmd_drop_d;
            irq_q       <= irq_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign blk_size_o  = blk_q[11:0];
    assign blk_cnt_o   = blk_q[31:16];
    assign cmd_arg_o   = arg_q;
    assign xfer_mode_o = cmdx_q[15:0];
    assign cmd_reg_o   = cmdx_q[31:16];
    assign adma_addr_o = adma_q[DMA_AW-1:0];
    assign cmd_start_o = cmd_start_q;
    assign cmd_drop_o  = cmd_drop_q;
    assign irq_o       = irq_q;
endmodule

// File: doc/sd_host_regfile.md
SD_HOST_REGFILE -- requirements
Module: sd_host_regfile

Interface
REQ-001 Parameter ADDR_W, default 13, byte-address width of host register port.
REQ-002 Parameter DMA_AW, default 64, ADMA system address width; legal values 32 or 64.
REQ-003 Parameter NIRQ, default 16, number of normal interrupt status bits (1..16).
REQ-004 CLK  in  1  single clock; RESET  in  1  reset, synchronous, active-high.
REQ-005 addrs  in  ADDR_W  byte address, bits [1:0] ignored (word access).
REQ-006 wr_en  in  1; wr_data  in  32; be  in  4  byte enables.
REQ-007 rd_en  in  1; rd_data  out  32; rd_valid  out  1.
REQ-008 hw_int_set  in  NIRQ  one-cycle event pulses; hw_err_set  in  16  error event pulses.
REQ-009 hw_resp_we  in  1; hw_resp  in  32  response capture from CMD engine.
REQ-010 cmd_busy  in  1; dat_busy  in  1  present-state inputs.
REQ-011 blk_size  out  12; blk_cnt  out  16; cmd_arg  out  32; xfer_mode  out  16; cmd_reg  out  16; adma_addr  out  DMA_AW.
REQ-012 cmd_start  out  1  one-cycle command launch pulse; cmd_drop  out  1  rejected-command pulse; irq  out  1.

Function
REQ-013 Word map (byte offset): 0x04 {blk_cnt,4'b0,blk_size}; 0x08 cmd_arg; 0x0C {cmd_reg,xfer_mode}; 0x10 response RO; 0x24 present state RO {30'b0,dat_busy,cmd_busy}; 0x30 {err_status,norm_status} W1C; 0x34 {err_en,norm_en} status enable; 0x38 {err_sig,norm_sig} signal enable; 0x58 adma_addr[31:0]; 0x5C adma_addr[63:32] (present only when DMA_AW=64).
REQ-014 Writes take effect on the CLK edge where wr_en=1, per enabled byte lane only; unmapped or RO offsets ignore writes.
REQ-015 Reads: rd_data and rd_valid registered, valid exactly 1 cycle after rd_en=1; rd_valid low otherwise; unmapped offsets (incl. 0x5C when DMA_AW=32) read 0.
REQ-016 rd_en and wr_en same cycle same address: read returns pre-write value.
REQ-017 Write to 0x0C with be[3]=1 and cmd_busy=0: cmd_reg updates, cmd_start=1 next cycle for exactly one cycle.
REQ-018 Same write with cmd_busy=1: cmd_reg and xfer_mode unchanged regardless of be, cmd_drop=1 next cycle for one cycle, no cmd_start.
REQ-019 Writes to 0x04/0x0C[15:0] while dat_busy=1 are ignored.
REQ-020 Status bit n sets when hw_*_set[n]=1 and its status-enable bit=1; clears on write-1 with lane enabled; hw set and W1C same cycle: bit ends set.
REQ-021 Status bits beyond NIRQ read 0 and never set; clearing enable bit does not clear an already set status bit.
REQ-022 Response register loads hw_resp on hw_resp_we; not software writable.
REQ-023 irq registered: irq = OR over (status AND signal enable), both halves, 1 cycle after the causing state change.
REQ-024 adma_addr upper bits write independently of lower; no carry or auto-increment.

Reset
REQ-025 RESET=1 at a CLK edge: all registers, status, enables 0; rd_data=0, rd_valid=0, cmd_start=0, cmd_drop=0, irq=0.
REQ-026 RESET dominates same-cycle wr_en, rd_en and hw event inputs; an in-flight read yields rd_valid=0.

Verification
REQ-027 Write 0x0C=0x1A3B_0010 be=4'hF cmd_busy=0 -> next cycle cmd_start=1 one cycle; read 0x0C returns 0x1A3B_0010.
REQ-028 Same write with cmd_busy=1 -> cmd_drop=1 one cycle, cmd_start=0, read 0x0C unchanged (0).
REQ-029 norm_en=0x0001, norm_sig=0x0001, hw_int_set=0x0001 -> status 0x0001, irq=1; write 0x30=0x0000_0001 with simultaneous hw_int_set=0x0001 -> status stays 1; W1C alone -> status 0, irq 0 next cycle.
REQ-030 Write 0x08=0xDEAD_BEEF be=4'b0101 -> cmd_arg=0x00AD_00EF.
REQ-031 DMA_AW=32: write 0x5C=0xFFFF_FFFF then read -> 0; DMA_AW=64 read -> 0xFFFF_FFFF, adma_addr[63:32]=0xFFFF_FFFF.
REQ-032 Assert RESET mid-read with status set -> all outputs 0 next cycle, rd_valid=0.
